ysyx_22050612_wb_arbiter: RTL

Writeback arbiter and scoreboard for the NPC integer register file. Shares the register file's single write port between two producers, the execute unit (requester 0) and the load/store unit (requester 1), using round-robin valid/ready arbitration. Drives a registered write port straight into the register file. Keeps a per-register busy scoreboard that the decode stage reads to detect pending writes.

---
 rtl/ysyx_22050612_pkg.sv | 11 +
 rtl/ysyx_22050612_rr_arb2.sv | 16 +
 rtl/ysyx_22050612_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/ysyx_22050612_pkg.sv
// Shared constants for the NPC writeback path: requester indices and default widths.
package ysyx_22050612_pkg;

    localparam int unsigned REQ_EXU       = 0;
    localparam int unsigned REQ_LSU       = 1;
    localparam int unsigned NUM_WB_REQ    = 2;

    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH = 64;

endpackage

// File: rtl/ysyx_22050612_rr_arb2.sv
// Combinational two-way round-robin grant; prio names the requester favoured on a tie.
module ysyx_22050612_rr_arb2
    import ysyx_22050612_pkg::*;
(
    input  logic [NUM_WB_REQ-1:0] valid,
    input  logic                  prio,
    output logic [NUM_WB_REQ-1:0] grant
);

    always_comb begin
        grant          = '0;
        grant[REQ_EXU] = valid[REQ_EXU] && (!valid[REQ_LSU] || !prio);
        grant[REQ_LSU] = valid[REQ_LSU] && (!valid[REQ_EXU] ||  prio);
    end

endmodule

// File: rtl/ysyx_22050612_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between EXU and LSU and tracks pending writes.
// Define YSYX_22050612_WB_TRACE_EN to print each register-file write with its source requester.
module ysyx_22050612_wb_arbiter
    import ysyx_22050612_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WB_REQ-1:0]            req_valid,
    output logic [NUM_WB_REQ-1:0]            req_ready,
    input  logic [NUM_WB_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WB_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]       busy,
    output logic                             rf_wen,
    output logic [ADDR_WIDTH-1:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0]            rf_wdata
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;

    logic                  prio;
    logic [NUM_WB_REQ-1:0] grant;
    logic                  hs;
    logic                  sel;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy_nxt;

    ysyx_22050612_rr_arb2 u_arb (
        .valid (req_valid),
        .prio  (prio),
        .grant (grant)
    );

    // Reset suppresses ready so no handshake can be consumed on the reset edge.
    always_comb begin
        req_ready = grant & {NUM_WB_REQ{!rst}};
        hs        = |req_ready;
        sel       = req_ready[REQ_LSU];
        sel_addr  = sel ? req_addr[REQ_LSU*ADDR_WIDTH +: ADDR_WIDTH]
                        : req_addr[REQ_EXU*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data  = sel ? req_data[REQ_LSU*DATA_WIDTH +: DATA_WIDTH]
                        : req_data[REQ_EXU*DATA_WIDTH +: DATA_WIDTH];
    end

    // Clear is applied before set so a same-edge issue to the retiring register stays busy.
    always_comb begin
        busy_nxt = busy;
        for (int unsigned a = 1; a < NUM_REGS; a++) begin
            if (rf_wen && rf_waddr == ADDR_WIDTH'(a)) begin
                busy_nxt[a] = 1'b0;
            end
            if (issue_valid && issue_addr == ADDR_WIDTH'(a)) begin
                busy_nxt[a] = 1'b1;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio     <= 1'b0;
            busy     <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            busy   <= busy_nxt;
            rf_wen <= hs && (sel_addr != '0);
            if (hs) begin
                prio     <= !sel;
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
        end
    end

`ifdef YSYX_22050612_WB_TRACE_EN
    logic rf_src;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_src <= 1'b0;
        end else if (hs) begin
            rf_src <= sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rf_wen) begin
            $display("wb x%0d <= 0x%h (%s)", rf_waddr, rf_wdata, rf_src ? "lsu" : "exu");
        end
    end
`endif

endmodule
